// File: rtl/xpb_serial_accum_if.sv
// Handshake and LUT-bank signals of the xpb serial accumulator.
// slave = the accumulator, master = upstream/LUT/consumer side.
interface xpb_serial_accum_if #(
  parameter int NUM_CHUNKS = 16,
  parameter int CHUNK_W    = 5,
  parameter int DATA_W     = 1024,
  parameter int SEL_W      = 4,
  parameter int ACC_W      = 1028
);
  logic                          in_valid;
  logic                          in_ready;
  logic [NUM_CHUNKS*CHUNK_W-1:0] in_data;
  logic [SEL_W-1:0]              lut_sel;
  logic [CHUNK_W-1:0]            lut_idx;
  logic                          lut_en;
  logic [DATA_W-1:0]             lut_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [ACC_W-1:0]              out_sum;

  modport slave (
    input  in_valid, in_data, lut_data, out_ready,
    output in_ready, lut_sel, lut_idx, lut_en, out_valid, out_sum
  );

  modport master (
    output in_valid, in_data, lut_data, out_ready,
    input  in_ready, lut_sel, lut_idx, lut_en, out_valid, out_sum
  );
endinterface

// File: rtl/xpb_serial_accum.sv
// Issues one (sel, idx) per cycle to the registered xpb LUT bank and sums the results.
// Optional XPB_SKIP_ZERO_EN: zero-index chunks are skipped via a priority search.
module xpb_serial_accum #(
  parameter int NUM_CHUNKS = 16,
  parameter int CHUNK_W    = 5,
  parameter int DATA_W     = 1024,
  parameter int SEL_W      = 4,
  parameter int ACC_W      = 1028
) (
  input logic                 clk,
  input logic                 rst_n,
  xpb_serial_accum_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                        state_reg;
  logic [NUM_CHUNKS*CHUNK_W-1:0] data_reg;
  logic                          in_ready_reg;
  logic                          lut_en_reg;
  logic [SEL_W-1:0]              lut_sel_reg;
  logic [CHUNK_W-1:0]            lut_idx_reg;
  logic                          pend_reg;
  logic                          out_valid_reg;
  logic [ACC_W-1:0]              acc_reg;

  logic [CHUNK_W-1:0] chunk [NUM_CHUNKS];
  // {found, chunk number}: first chunk of a new word, and next chunk after lut_sel
  logic [SEL_W:0]     first_in;
  logic [SEL_W:0]     next_hit;

  generate
    for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunk
      assign chunk[gi] = data_reg[gi*CHUNK_W +: CHUNK_W];
    end
  endgenerate

`ifdef XPB_SKIP_ZERO_EN
  logic [NUM_CHUNKS-1:0] nz_in;
  logic [NUM_CHUNKS-1:0] nz_reg;

  generate
    for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_nz
      assign nz_in[gi]  = |bus.in_data[gi*CHUNK_W +: CHUNK_W];
      assign nz_reg[gi] = |chunk[gi];
    end
  endgenerate

  // Lowest nonzero chunk at or above start; scanning downward lets the lowest win.
  function automatic logic [SEL_W:0] first_nz(input logic [NUM_CHUNKS-1:0] nz,
                                               input logic [SEL_W:0] start);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = NUM_CHUNKS - 1; i >= 0; i--) begin
      if (nz[i] && ((SEL_W+1)'(i) >= start)) r = {1'b1, SEL_W'(i)};
    end
    return r;
  endfunction

  assign first_in = first_nz(nz_in, '0);
  assign next_hit = first_nz(nz_reg, {1'b0, lut_sel_reg} + 1'b1);
`else
  assign first_in = {1'b1, {SEL_W{1'b0}}};
  assign next_hit = {(lut_sel_reg != SEL_W'(NUM_CHUNKS - 1)), lut_sel_reg + 1'b1};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      data_reg      <= '0;
      in_ready_reg  <= 1'b1;
      lut_en_reg    <= 1'b0;
      lut_sel_reg   <= '0;
      lut_idx_reg   <= '0;
      pend_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      acc_reg       <= '0;
    end else begin
      // LUT output lands one cycle after each issue
      pend_reg <= lut_en_reg;
      if (state_reg == IDLE && bus.in_valid && in_ready_reg)
        acc_reg <= '0;
      else if (pend_reg)
        acc_reg <= acc_reg + ACC_W'(bus.lut_data);

      case (state_reg)
        IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            data_reg     <= bus.in_data;
            in_ready_reg <= 1'b0;
            if (first_in[SEL_W]) begin
              state_reg   <= ISSUE;
              lut_en_reg  <= 1'b1;
              lut_sel_reg <= first_in[SEL_W-1:0];
              lut_idx_reg <= bus.in_data[first_in[SEL_W-1:0]*CHUNK_W +: CHUNK_W];
            end else begin
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (next_hit[SEL_W]) begin
            lut_sel_reg <= next_hit[SEL_W-1:0];
            lut_idx_reg <= chunk[next_hit[SEL_W-1:0]];
          end else begin
            lut_en_reg <= 1'b0;
            state_reg  <= DRAIN;
          end
        end
        DRAIN: begin
          state_reg     <= DONE;
          out_valid_reg <= 1'b1;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.lut_en    = lut_en_reg;
  assign bus.lut_sel   = lut_sel_reg;
  assign bus.lut_idx   = lut_idx_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_sum   = acc_reg;

endmodule

// File: tb/tb_xpb_serial_accum.sv
// Randomized bench for xpb_serial_accum against a sum-of-LUT-values reference model.
// Build with +define+XPB_SKIP_ZERO_EN to exercise the zero-skip variant.
module tb_xpb_serial_accum;
  localparam int N     = 16;
  localparam int CW    = 5;
  localparam int DW    = 1024;
  localparam int SW    = 4;
  localparam int AW    = 1028;
  localparam int IN_W  = N * CW;

  logic clk;
  logic rst_n;
  int   lut_mode;
  int   n_vec;
  int   n_err;

  xpb_serial_accum_if #(.NUM_CHUNKS(N), .CHUNK_W(CW), .DATA_W(DW), .SEL_W(SW), .ACC_W(AW)) bus ();

  xpb_serial_accum #(.NUM_CHUNKS(N), .CHUNK_W(CW), .DATA_W(DW), .SEL_W(SW), .ACC_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered LUT: valid one cycle after lut_en, garbage otherwise
  always @(posedge clk) begin
    if (bus.lut_en) begin
      case (lut_mode)
        1:       bus.lut_data <= '1;
        2:       bus.lut_data <= DW'(bus.lut_idx);
        default: bus.lut_data <= DW'({bus.lut_sel, bus.lut_idx});
      endcase
    end else begin
      bus.lut_data <= {32{$urandom()}};
    end
  end

  task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h..%h want %h..%h", tag, got[AW-1:AW-36], got[63:0],
               exp[AW-1:AW-36], exp[63:0]);
    end
  endtask

  function automatic logic [AW-1:0] lut_val(input int mode, input int sel, input int idx);
    case (mode)
      1:       return {4'b0, {DW{1'b1}}};
      2:       return AW'(idx);
      default: return AW'(sel * 32 + idx);
    endcase
  endfunction

  function automatic logic [IN_W-1:0] kp1_data();
    logic [IN_W-1:0] d;
    for (int k = 0; k < N; k++) d[k*CW +: CW] = CW'(k + 1);
    return d;
  endfunction

  task automatic run_txn(input string tag, input logic [IN_W-1:0] data, input int mode,
                         input bit early_ready, input int hold);
    logic [AW-1:0] exp_sum;
    int exp_q[$];
    int nz, lat, got_lat, issues, idx, want;
    exp_sum = '0;
    nz      = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(data[k*CW +: CW]);
`ifdef XPB_SKIP_ZERO_EN
      if (idx == 0) continue;
`endif
      exp_q.push_back(k * 32 + idx);
      exp_sum += lut_val(mode, k, idx);
      nz++;
    end
`ifdef XPB_SKIP_ZERO_EN
    lat = (nz == 0) ? 1 : nz + 2;
`else
    lat = N + 2;
`endif
    lut_mode = mode;
    chk({tag, ".idle_ready"}, AW'(bus.in_ready), 1);
    bus.in_data   = data;
    bus.in_valid  = 1'b1;
    bus.out_ready = early_ready;
    @(posedge clk);
    got_lat = 0;
    issues  = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) bus.in_valid = 1'b0;
      chk({tag, ".busy_ready"}, AW'(bus.in_ready), 0);
      if (bus.lut_en) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk({tag, ".issue"}, AW'({bus.lut_sel, bus.lut_idx}), AW'(want));
        issues++;
      end
      if (bus.out_valid) begin
        got_lat = c;
        break;
      end
    end
    if (hold > 0) bus.out_ready = 1'b0;
    chk({tag, ".latency"}, AW'(got_lat), AW'(lat));
    chk({tag, ".n_issue"}, AW'(issues), AW'(nz));
    chk({tag, ".sum"}, bus.out_sum, exp_sum);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, AW'(bus.out_valid), 1);
      chk({tag, ".hold_sum"}, bus.out_sum, exp_sum);
      chk({tag, ".hold_ready"}, AW'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, ".ready_after"}, AW'(bus.in_ready), 1);
    chk({tag, ".valid_after"}, AW'(bus.out_valid), 0);
    $display("txn %s data=%h mode=%0d lat=%0d sum_lo=%h", tag, data, mode, got_lat, bus.out_sum[63:0]);
  endtask

  task automatic reset_mid_op();
    int seen;
    lut_mode     = 0;
    bus.in_data  = kp1_data();
    bus.in_valid = 1'b1;
    @(posedge clk);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (bus.lut_en && bus.lut_sel == SW'(7)) begin
        seen = 1;
        break;
      end
    end
    chk("rst.reach_sel7", AW'(seen), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.in_ready", AW'(bus.in_ready), 1);
    chk("rst.lut_en", AW'(bus.lut_en), 0);
    chk("rst.lut_sel", AW'(bus.lut_sel), 0);
    chk("rst.lut_idx", AW'(bus.lut_idx), 0);
    chk("rst.out_valid", AW'(bus.out_valid), 0);
    chk("rst.out_sum", bus.out_sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn reset_mid_op asserted at sel=7");
  endtask

  initial begin
    logic [IN_W-1:0] d;
    n_vec = 0;
    n_err = 0;
    lut_mode      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.in_ready", AW'(bus.in_ready), 1);
    chk("reset.lut_en", AW'(bus.lut_en), 0);
    chk("reset.lut_sel", AW'(bus.lut_sel), 0);
    chk("reset.lut_idx", AW'(bus.lut_idx), 0);
    chk("reset.out_valid", AW'(bus.out_valid), 0);
    chk("reset.out_sum", bus.out_sum, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn("zero", '0, 2, 1'b0, 0);
    run_txn("all_ones", {N{5'h1F}}, 1, 1'b0, 0);
    chk("all_ones.const", bus.out_sum, {{(AW-4){1'b1}}, 4'h0});
    run_txn("kp1", kp1_data(), 0, 1'b1, 0);
`ifndef XPB_SKIP_ZERO_EN
    chk("kp1.const", bus.out_sum, AW'(12'hF88));
`endif
    run_txn("kp1_hold5", kp1_data(), 0, 1'b0, 5);
    reset_mid_op();
    run_txn("kp1_after_rst", kp1_data(), 0, 1'b0, 0);
    d = '0;
    d[3*CW +: CW] = 5'd5;
    run_txn("chunk3_only", d, 0, 1'b0, 1);
    run_txn("zero_sel", '0, 0, 1'b1, 0);

    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < N; k++)
        d[k*CW +: CW] = ($urandom_range(0, 3) == 0) ? 5'd0 : CW'($urandom_range(1, 31));
      run_txn($sformatf("rand%0d", t), d, int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
